// File: rtl/paillier_result_arbiter_if.sv
// Result stream bundle: per-engine FIFO read side plus the merged K-bit valid/ready output.
// The arbiter uses the master modport; the FIFO/downstream environment uses slave.
interface paillier_result_arbiter_if #(
  parameter int unsigned BLOCK_COUNT = 18,
  parameter int unsigned K           = 128,
  parameter int unsigned N           = 32,
  parameter int unsigned CW          = $clog2(N) + 2,
  parameter int unsigned IW          = $clog2(BLOCK_COUNT)
);
  logic [BLOCK_COUNT*CW-1:0] fifo_rd_cnt;
  logic [BLOCK_COUNT*K-1:0]  fifo_rd_dout;
  logic [BLOCK_COUNT-1:0]    fifo_rd_rdy;
  logic [K-1:0]              m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_last;
  logic [IW-1:0]             m_id;

  modport master (
    input  fifo_rd_cnt, fifo_rd_dout, m_ready,
    output fifo_rd_rdy, m_data, m_valid, m_last, m_id
  );

  modport slave (
    output fifo_rd_cnt, fifo_rd_dout, m_ready,
    input  fifo_rd_rdy, m_data, m_valid, m_last, m_id
  );
endinterface

// File: rtl/paillier_result_arbiter.sv
// Round-robin drain of per-engine result FIFOs into one stream; each complete N-word result
// goes out as an uninterrupted burst, and completed results are counted against task_total.
module paillier_result_arbiter #(
  parameter int unsigned BLOCK_COUNT = 18,
  parameter int unsigned K           = 128,
  parameter int unsigned N           = 32,
  parameter int unsigned CW          = $clog2(N) + 2,
  parameter int unsigned IW          = $clog2(BLOCK_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       enable,
  input  logic [15:0]                task_total,
  paillier_result_arbiter_if.master  bus,
  output logic                       busy,
  output logic [15:0]                result_cnt,
  output logic                       done
);
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {StArb, StXfer} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [15:0]          result_cnt_q, result_cnt_d;
  logic                 done_q, done_d;
  logic [BLOCK_COUNT-1:0] elig;
  logic                 found;
  logic [IW-1:0]        sel;
  int unsigned          idx;
  logic                 xfer, handshake, beat_last;

  always_comb begin
    for (int unsigned i = 0; i < BLOCK_COUNT; i++) begin
      elig[i] = bus.fifo_rd_cnt[i*CW +: CW] >= CW'(N);
    end
  end

  // First eligible engine after the last one served, wrapping past BLOCK_COUNT-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned o = 1; o <= BLOCK_COUNT; o++) begin
      idx = 32'(last_grant_q) + o;
      if (idx >= BLOCK_COUNT) idx = idx - BLOCK_COUNT;
      if (!found && elig[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StArb;
      grant_q      <= '0;
      last_grant_q <= IW'(BLOCK_COUNT - 1);
      beat_q       <= '0;
      result_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      result_cnt_q <= result_cnt_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    result_cnt_d = result_cnt_q;
    done_d       = done_q | ((task_total != 16'd0) && (result_cnt_q >= task_total));

    xfer      = (state_q == StXfer);
    beat_last = (beat_q == BW'(N - 1));
    // clr suppresses valid so the abandoned beat is neither popped nor accepted downstream.
    bus.m_valid = xfer && !clr;
    handshake   = bus.m_valid && bus.m_ready;
    bus.m_last  = bus.m_valid && beat_last;
    bus.m_id    = grant_q;
    bus.m_data  = bus.fifo_rd_dout[grant_q*K +: K];
    bus.fifo_rd_rdy = '0;
    if (handshake) bus.fifo_rd_rdy[grant_q] = 1'b1;

    if (clr) begin
      state_d      = StArb;
      grant_d      = '0;
      last_grant_d = IW'(BLOCK_COUNT - 1);
      beat_d       = '0;
      result_cnt_d = '0;
      done_d       = 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (enable && found) begin
            grant_d = sel;
            beat_d  = '0;
            state_d = StXfer;
          end
        end
        StXfer: begin
          if (handshake) begin
            beat_d = beat_q + 1'b1;
            if (beat_last) begin
              last_grant_d = grant_q;
              if (result_cnt_q != 16'hFFFF) result_cnt_d = result_cnt_q + 16'd1;
              state_d = StArb;
            end
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  assign busy       = (state_q == StXfer);
  assign result_cnt = result_cnt_q;
  assign done       = done_q;
endmodule

// File: tb/tb_paillier_result_arbiter.sv
// Bench: behavioural show-ahead FIFOs feed the arbiter; a forked monitor checks every output
// beat against a queue of expected beats pushed by the directed stimulus.
module tb_paillier_result_arbiter;
  localparam int unsigned BC = 18;
  localparam int unsigned K  = 128;
  localparam int unsigned N  = 32;
  localparam int unsigned CW = $clog2(N) + 2;
  localparam int unsigned IW = $clog2(BC);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] task_total = 16'd0;
  logic        busy, done;
  logic [15:0] result_cnt;

  always #5 clk = ~clk;

  paillier_result_arbiter_if #(.BLOCK_COUNT(BC), .K(K), .N(N)) bus ();

  paillier_result_arbiter #(.BLOCK_COUNT(BC), .K(K), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .enable     (enable),
    .task_total (task_total),
    .bus        (bus),
    .busy       (busy),
    .result_cnt (result_cnt),
    .done       (done)
  );

  // FIFO model: occupancy = wr - rd, head = mem[rd].
  logic [K-1:0] mem [BC][64];
  int unsigned  wr [BC];
  int unsigned  rd [BC];
  int unsigned  wseq [BC];
  int unsigned  exp_seq [BC];
  int           underflow = 0;

  always_comb begin
    for (int i = 0; i < BC; i++) begin
      bus.fifo_rd_cnt[i*CW +: CW] = CW'(wr[i] - rd[i]);
      bus.fifo_rd_dout[i*K +: K]  = mem[i][rd[i][5:0]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < BC; i++) begin
      if (bus.fifo_rd_rdy[i]) begin
        if (wr[i] == rd[i]) underflow <= underflow + 1;
        else rd[i] <= rd[i] + 1;
      end
    end
  end

  typedef struct packed {
    logic [K-1:0]  data;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  beat_t expq [$];
  int    errors = 0;
  int    checks = 0;
  int    hs_cnt = 0;
  int    exp_total = 0;

  function automatic logic [K-1:0] mkword(int unsigned e, int unsigned s);
    logic [K-1:0] w;
    w            = '0;
    w[31:0]      = s;
    w[47:32]     = e[15:0];
    w[K-1 -: 16] = s[15:0] ^ 16'hA5C3;
    return w;
  endfunction

  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int unsigned e, input int unsigned n);
    for (int unsigned j = 0; j < n; j++) begin
      mem[e][wr[e][5:0]] = mkword(e, wseq[e]);
      wseq[e]++;
      wr[e]++;
    end
  endtask

  task automatic expect_burst(input int unsigned e, input int unsigned n);
    beat_t b;
    for (int unsigned j = 0; j < n; j++) begin
      b.data = mkword(e, exp_seq[e]);
      b.id   = IW'(e);
      b.last = (j == N - 1);
      expq.push_back(b);
      exp_seq[e]++;
      exp_total++;
    end
  endtask

  // Steps cycles (resuming #1 after each rising edge) until all expected beats are seen.
  task automatic run(input bit toggle, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (hs_cnt < exp_total && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
      if (toggle) bus.m_ready = !bus.m_ready;
      if (busy) busy_cycles++;
    end
    if (hs_cnt < exp_total) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d beats, expected %0d", hs_cnt, exp_total);
    end
  endtask

  task automatic monitor();
    logic          stall = 1'b0;
    logic [K-1:0]  pd = '0;
    logic [IW-1:0] pid = '0;
    logic [K-1:0]  oh;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall && !clr) begin
          chk("hold_valid", K'(bus.m_valid), K'(1'b1));
          chk("hold_data", bus.m_data, pd);
          chk("hold_id", K'(bus.m_id), K'(pid));
        end
        if (bus.m_valid && bus.m_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got id %0d, expected no beat", bus.m_id);
          end else begin
            e = expq.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            chk("beat_data", bus.m_data, e.data);
            chk("beat_id", K'(bus.m_id), K'(e.id));
            chk("beat_last", K'(bus.m_last), K'(e.last));
            chk("pop_strobe", K'(bus.fifo_rd_rdy), oh);
          end
          hs_cnt++;
        end else begin
          chk("rdy_idle", K'(bus.fifo_rd_rdy), K'(0));
        end
        stall = bus.m_valid && !bus.m_ready;
        pd    = bus.m_data;
        pid   = bus.m_id;
      end
    end
  endtask

  int cyc, bcyc;

  initial begin
    bus.m_ready = 1'b0;
    fork
      monitor();
    join_none

    #1;
    chk("rst_valid", K'(bus.m_valid), K'(0));
    chk("rst_busy", K'(busy), K'(0));
    chk("rst_id", K'(bus.m_id), K'(0));
    chk("rst_cnt", K'(result_cnt), K'(0));
    chk("rst_done", K'(done), K'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    task_total = 16'd18;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;

    // Single engine 5: one ARB cycle, then 32 back-to-back beats.
    push(5, 32);
    expect_burst(5, 32);
    @(negedge clk);
    chk("t1_arb_valid", K'(bus.m_valid), K'(0));
    run(1'b0, cyc, bcyc);
    chk("t1_cycles", K'(cyc), K'(33));
    chk("t1_busy_cycles", K'(bcyc), K'(32));
    chk("t1_result_cnt", K'(result_cnt), K'(1));
    chk("t1_fifo5_empty", K'(wr[5] - rd[5]), K'(0));

    // All engines full after clr: served 0..17, one ARB cycle between bursts.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int unsigned e = 0; e < BC; e++) push(e, 32);
    for (int unsigned e = 0; e < BC; e++) expect_burst(e, 32);
    run(1'b0, cyc, bcyc);
    chk("t2_cycles", K'(cyc), K'(18 * 33));
    chk("t2_result_cnt", K'(result_cnt), K'(18));
    chk("t2_done_lag", K'(done), K'(0));
    @(posedge clk); #1;
    chk("t2_done", K'(done), K'(1));

    // Wrap-around: 17 served, then 3 and 16 appear; order 17, 3, 16.
    push(17, 32);
    expect_burst(17, 32);
    repeat (3) begin @(posedge clk); #1; end
    push(3, 32);
    push(16, 32);
    expect_burst(3, 32);
    expect_burst(16, 32);
    run(1'b0, cyc, bcyc);
    chk("t3_result_cnt", K'(result_cnt), K'(21));
    chk("t3_done_sticky", K'(done), K'(1));

    // Backpressure: m_ready alternates each cycle, burst occupies 64 cycles.
    push(7, 32);
    expect_burst(7, 32);
    run(1'b1, cyc, bcyc);
    bus.m_ready = 1'b1;
    chk("t4_cycles", K'(cyc), K'(65));
    chk("t4_busy_cycles", K'(bcyc), K'(64));
    chk("t4_fifo7_empty", K'(wr[7] - rd[7]), K'(0));

    // 31 words never qualify; the 32nd makes engine 2 eligible.
    push(2, 31);
    bcyc = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy) bcyc++;
    end
    chk("t5_no_grant", K'(bcyc), K'(0));
    chk("t5_fifo2_cnt", K'(wr[2] - rd[2]), K'(31));
    push(2, 1);
    expect_burst(2, 32);
    @(negedge clk);
    chk("t5_arb_valid", K'(bus.m_valid), K'(0));
    run(1'b0, cyc, bcyc);
    chk("t5_cycles", K'(cyc), K'(33));

    // clr at beat 10 of engine 4 abandons the rest of the burst.
    push(4, 32);
    expect_burst(4, 10);
    run(1'b0, cyc, bcyc);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t6_busy", K'(busy), K'(0));
    chk("t6_valid", K'(bus.m_valid), K'(0));
    chk("t6_result_cnt", K'(result_cnt), K'(0));
    chk("t6_done", K'(done), K'(0));
    chk("t6_fifo4_cnt", K'(wr[4] - rd[4]), K'(22));

    // Async reset mid-burst takes effect with no clock edge.
    push(4, 10);
    expect_burst(4, 5);
    run(1'b0, cyc, bcyc);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", K'(bus.m_valid), K'(0));
    chk("t6_rst_busy", K'(busy), K'(0));
    chk("t6_rst_id", K'(bus.m_id), K'(0));
    chk("t6_rst_last", K'(bus.m_last), K'(0));
    chk("t6_rst_rdy", K'(bus.fifo_rd_rdy), K'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_fifo4_after_rst", K'(wr[4] - rd[4]), K'(27));
    chk("t6_idle_after_rst", K'(busy), K'(0));

    chk("scoreboard_empty", K'(expq.size()), K'(0));
    chk("no_underflow", K'(underflow), K'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
